// File: rtl/deint_pkg.sv
// Shared deinterlacer types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deint_pkg;

    // Default pixel width used across the deinterlacer blocks.
    localparam int DEINT_DATA_W = 8;

    // Bob line sequencer phases: pass-through, interpolate, replay, duplicate bottom line.
    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_INTERP = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DUP    = 2'd3
    } bob_state_t;

endpackage

// File: rtl/sum_div2.sv
// Floor average of two pixels: floor((a+b)/2) via a DATA_W+1 bit sum.
// Latency: combinational.
// Backpressure: none (pure function).
module sum_div2 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W:0] sum;

    // Extra carry bit keeps the sum exact; dropping bit 0 truncates toward zero.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        out = sum[DATA_W:1];
    end

endmodule

// File: rtl/bob_line_sequencer.sv
// Bob deinterlacer: turns one field into a 2*LINES progressive frame using one line buffer.
// Latency: one cycle from accepted input (or replayed buffer read) to out_valid.
// Backpressure: single output register; holds while out_valid && !out_ready, in_ready low then and in REPLAY/DUP.
module bob_line_sequencer
    import deint_pkg::*;
#(
    parameter int DATA_W   = DEINT_DATA_W,
    parameter int LINE_LEN = 16,
    parameter int LINES    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_interp,
    output logic              out_sol,
    output logic              out_sof
);

    localparam int COL_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

    logic [DATA_W-1:0] line_buf [LINE_LEN];
    bob_state_t        state;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;

    logic              load;
    logic              take_in;
    logic              emit;
    logic              last_col;
    logic              accepting_state;
    logic [DATA_W-1:0] buf_rd;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] nxt_data;

    sum_div2 #(.DATA_W(DATA_W)) u_avg (
        .a   (buf_rd),
        .b   (in_data),
        .out (avg)
    );

    // Handshake and output-mux selection; reset masks in_ready so nothing is taken during the reset cycle.
    always_comb begin
        load            = !out_valid || out_ready;
        accepting_state = (state == ST_FIRST) || (state == ST_INTERP);
        in_ready        = !reset && accepting_state && load;
        take_in         = in_valid && in_ready;
        emit            = take_in || (!reset && load && !accepting_state);
        last_col        = (col == COL_W'(LINE_LEN - 1));
        buf_rd          = line_buf[col];
        nxt_data        = buf_rd;
        case (state)
            ST_FIRST:  nxt_data = in_data;
            ST_INTERP: nxt_data = avg;
            default:   nxt_data = buf_rd;
        endcase
    end

    // Line buffer: read-old/write-new at the same column; contents need no reset.
    always_ff @(posedge clock) begin
        if (take_in) begin
            line_buf[col] <= in_data;
        end
    end

    // Sequencer FSM, counters and output register; everything advances only when a pixel is loaded.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_FIRST;
            col        <= '0;
            line       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_interp <= 1'b0;
            out_sol    <= 1'b0;
            out_sof    <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= emit;
            end
            if (emit) begin
                out_data   <= nxt_data;
                out_interp <= (state == ST_INTERP);
                out_sol    <= (col == '0);
                out_sof    <= (state == ST_FIRST) && (col == '0);
                col        <= last_col ? '0 : col + COL_W'(1);
                if (last_col) begin
                    case (state)
                        ST_FIRST: begin
                            state <= ST_INTERP;
                            line  <= LINE_W'(1);
                        end
                        ST_INTERP: state <= ST_REPLAY;
                        ST_REPLAY: begin
                            if (line == LINE_W'(LINES - 1)) begin
                                state <= ST_DUP;
                            end else begin
                                line  <= line + LINE_W'(1);
                                state <= ST_INTERP;
                            end
                        end
                        default: begin
                            state <= ST_FIRST;
                            line  <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bob_line_sequencer.sv
module tb_bob_line_sequencer;
    localparam int DW = 8;
    localparam int LL = 4;
    localparam int NL = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_interp;
    logic          out_sol;
    logic          out_sof;

    always #5 clock = ~clock;

    bob_line_sequencer #(.DATA_W(DW), .LINE_LEN(LL), .LINES(NL)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_interp (out_interp),
        .out_sol    (out_sol),
        .out_sof    (out_sof)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          interp;
        logic          sol;
        logic          sof;
    } pix_t;

    pix_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            field [NL][LL];

    int n_cmp = 0;
    int n_bad = 0;

    // monitor-owned counters (main only snapshots them)
    int cyc = 0, acc_cnt = 0, xfer_cnt = 0, ir_low = 0, sof_cnt = 0, sol_cnt = 0;
    int interp_cnt = 0, stall_cnt = 0, restarts = 0, last_xfer_cyc = -10;
    bit prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic [2:0]    prev_f;

    // stimulus knobs (main only)
    bit mon_en = 0;
    int valid_pct = 100, ready_pct = 100;
    bit bp_arm = 0;
    int bp_base = 0;
    int stall_left = 0;
    int acc_seen = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic pix_t mk(input int d, input bit interp, input bit sol, input bit sof);
        pix_t p;
        p.d = DW'(d);
        p.interp = interp;
        p.sol = sol;
        p.sof = sof;
        return p;
    endfunction

    // Reference: each field line, then either the average with the next line or the line again.
    task automatic load_field();
        for (int k = 0; k < NL; k++)
            for (int c = 0; c < LL; c++)
                src_q.push_back(DW'(field[k][c]));
        for (int k = 0; k < NL; k++) begin
            for (int c = 0; c < LL; c++)
                exp_q.push_back(mk(field[k][c], 1'b0, c == 0, (k == 0) && (c == 0)));
            for (int c = 0; c < LL; c++) begin
                if (k < NL - 1)
                    exp_q.push_back(mk((field[k][c] + field[k+1][c]) / 2, 1'b1, c == 0, 1'b0));
                else
                    exp_q.push_back(mk(field[k][c], 1'b0, c == 0, 1'b0));
            end
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NL; k++)
            for (int c = 0; c < LL; c++)
                field[k][c] = 16 * k + c;
    endtask

    task automatic set_random();
        for (int k = 0; k < NL; k++)
            for (int c = 0; c < LL; c++)
                field[k][c] = int'($urandom_range(255));
    endtask

    // One cycle of stimulus, driven 1 time unit after the rising edge.
    task automatic step();
        bit was_acc;
        @(posedge clock);
        #1;
        was_acc  = (acc_cnt != acc_seen);
        acc_seen = acc_cnt;
        if (was_acc) void'(src_q.pop_front());
        if (!(in_valid && !was_acc))
            in_valid = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
        in_data = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
        if (bp_arm && (xfer_cnt - bp_base) == 6) begin
            stall_left = 5;
            bp_arm = 0;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_timeout_left"}, exp_q.size() + src_q.size(), 0);
    endtask

    // Monitor: sampled on the falling edge, sees what the next rising edge will transfer.
    always @(negedge clock) begin
        pix_t e;
        cyc++;
        if (mon_en && !reset) begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, prev_d);
                check_eq("hold_flags", {out_interp, out_sol, out_sof}, prev_f);
            end
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", in_ready, 0);
                stall_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_f = {out_interp, out_sol, out_sof};
            if (in_valid && in_ready) acc_cnt++;
            if (!in_ready) ir_low++;
            if (out_valid && out_ready) begin
                if (cyc != last_xfer_cyc + 1) restarts++;
                last_xfer_cyc = cyc;
                xfer_cnt++;
                sof_cnt += int'(out_sof);
                sol_cnt += int'(out_sol);
                interp_cnt += int'(out_interp);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pixel", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("data", out_data, e.d);
                    check_eq("interp", out_interp, e.interp);
                    check_eq("sol", out_sol, e.sol);
                    check_eq("sof", out_sof, e.sof);
                end
            end
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        int b_sof, b_sol, b_int, b_x, b_st, b_ir, b_rs, n;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        @(posedge clock);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_flags", {out_interp, out_sol, out_sof}, 0);
        reset = 1'b0;
        #1;
        check_eq("idle_in_ready", in_ready, 1);
        mon_en = 1;

        // ramp, full throughput
        set_ramp();
        b_sof = sof_cnt; b_sol = sol_cnt; b_int = interp_cnt;
        valid_pct = 100; ready_pct = 100;
        load_field();
        wait_done(200, "ramp");
        check_eq("ramp_sof_cnt", sof_cnt - b_sof, 1);
        check_eq("ramp_sol_cnt", sol_cnt - b_sol, 2 * NL);
        check_eq("ramp_interp_cnt", interp_cnt - b_int, (NL - 1) * LL);

        // rounding corners
        for (int c = 0; c < LL; c++) begin
            field[0][c] = 255; field[1][c] = 254; field[2][c] = int'($urandom_range(255));
        end
        load_field();
        for (int c = 0; c < LL; c++) begin
            field[0][c] = 1; field[1][c] = 2; field[2][c] = int'($urandom_range(255));
        end
        load_field();
        valid_pct = 80; ready_pct = 80;
        wait_done(500, "round");

        // backpressure at INTERP col 2
        set_ramp();
        valid_pct = 100; ready_pct = 100;
        b_x = xfer_cnt; b_st = stall_cnt;
        bp_base = xfer_cnt;
        bp_arm = 1;
        load_field();
        wait_done(300, "bp");
        check_eq("bp_stall_cycles", stall_cnt - b_st, 5);
        check_eq("bp_xfer_cnt", xfer_cnt - b_x, 2 * NL * LL);

        // random data, random handshakes
        valid_pct = 60; ready_pct = 50;
        for (int f = 0; f < 4; f++) begin
            set_random();
            load_field();
        end
        wait_done(3000, "rand");

        // two fields back-to-back, continuous flow
        valid_pct = 100; ready_pct = 100;
        b_x = xfer_cnt; b_sof = sof_cnt; b_sol = sol_cnt; b_ir = ir_low; b_rs = restarts;
        set_ramp();
        load_field();
        set_random();
        load_field();
        wait_done(300, "b2b");
        check_eq("b2b_xfer_cnt", xfer_cnt - b_x, 4 * NL * LL);
        check_eq("b2b_restarts", restarts - b_rs, 1);
        check_eq("b2b_sof_cnt", sof_cnt - b_sof, 2);
        check_eq("b2b_sol_cnt", sol_cnt - b_sol, 4 * NL);
        check_eq("b2b_in_ready_low", ir_low - b_ir, 2 * NL * LL);

        // reset in the middle of INTERP line 1, column 2
        set_ramp();
        load_field();
        b_x = acc_cnt;
        n = 0;
        while ((acc_cnt - b_x) < LL + 2 && n < 100) begin
            step();
            n++;
        end
        check_eq("midrst_reach", acc_cnt - b_x, LL + 2);
        mon_en = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        src_q.delete();
        exp_q.delete();
        #1;
        check_eq("midrst_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_flags", {out_interp, out_sol, out_sof}, 0);
        reset = 1'b0;
        acc_seen = acc_cnt;
        mon_en = 1;
        set_random();
        load_field();
        wait_done(300, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
